// File: rtl/dut_signature_misr.sv
// Compacts the DUT result bus into a MISR signature over a programmed number of cycles,
// after an optional warm-up window, and returns it through a valid/ready handshake.
module dut_signature_misr #(
  parameter int                DATA_W   = 241,
  parameter int                SIG_W    = 32,
  parameter logic [SIG_W-1:0]  POLY     = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SEED     = 32'hFFFFFFFF,
  parameter int                WARM_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       num_cycles,
  input  logic [DATA_W-1:0] y_in,
  output logic              busy,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [SIG_W-1:0]  signature
);

  localparam int NSL    = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int WCNT_W = (WARM_CYC > 0) ? $clog2(WARM_CYC + 1) : 1;
  localparam int WLAST  = (WARM_CYC > 0) ? WARM_CYC - 1 : 0;

  typedef enum logic [1:0] {IDLE, WARMUP, CAPTURE, HOLD} state_t;

  state_t              state;
  logic [15:0]         ncyc;
  logic [15:0]         scnt;
  logic [WCNT_W-1:0]   wcnt;

  // XOR of all SIG_W-bit slices; the top slice is zero-padded.
  function automatic logic [SIG_W-1:0] fold(input logic [DATA_W-1:0] y);
    logic [NSL*SIG_W-1:0] ext;
    logic [SIG_W-1:0]     f;
    ext = '0;
    ext[DATA_W-1:0] = y;
    f = '0;
    for (int k = 0; k < NSL; k++) f = f ^ ext[k*SIG_W +: SIG_W];
    return f;
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] f);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ f;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      sig_valid <= 1'b0;
      signature <= SEED;
      ncyc      <= '0;
      scnt      <= '0;
      wcnt      <= '0;
    end else if (abort && state != IDLE) begin
      state     <= IDLE;
      busy      <= 1'b0;
      sig_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ncyc      <= num_cycles;
            signature <= SEED;
            scnt      <= '0;
            wcnt      <= '0;
            busy      <= 1'b1;
            if (WARM_CYC > 0) begin
              state <= WARMUP;
            end else if (num_cycles != 16'd0) begin
              state <= CAPTURE;
            end else begin
              state     <= HOLD;
              sig_valid <= 1'b1;
            end
          end
        end
        WARMUP: begin
          if (wcnt == WCNT_W'(WLAST)) begin
            if (ncyc != 16'd0) begin
              state <= CAPTURE;
            end else begin
              state     <= HOLD;
              sig_valid <= 1'b1;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        CAPTURE: begin
          signature <= misr_step(signature, fold(y_in));
          if (scnt == ncyc - 16'd1) begin
            state     <= HOLD;
            sig_valid <= 1'b1;
          end else begin
            scnt <= scnt + 16'd1;
          end
        end
        HOLD: begin
          if (sig_ready) begin
            state     <= IDLE;
            sig_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dut_signature_misr.sv
// Bench for dut_signature_misr with no warm-up window: constant vectors, scoreboarded
// streamed runs, HOLD back-pressure, abort and mid-run reset.
module tb_dut_signature_misr;
  localparam int          DATA_W = 241;
  localparam int          SIG_W  = 32;
  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam logic [31:0] SEED   = 32'hFFFFFFFF;

  logic              clk = 1'b0;
  logic              rst, start, abort, sig_ready, busy, sig_valid;
  logic [15:0]       num_cycles;
  logic [DATA_W-1:0] y_in;
  logic [SIG_W-1:0]  signature;

  int n_checks = 0;
  int n_fail   = 0;
  logic [SIG_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] ystream [0:127];

  typedef struct {
    logic [15:0]       n;
    logic [DATA_W-1:0] y;
    logic [31:0]       exp;
  } vec_t;
  vec_t vt [6];

  dut_signature_misr #(.DATA_W(DATA_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED), .WARM_CYC(0)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_cycles(num_cycles),
    .y_in(y_in), .busy(busy), .sig_valid(sig_valid), .sig_ready(sig_ready),
    .signature(signature)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Bitwise reference: bit i of y lands in signature bit (i mod SIG_W).
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [DATA_W-1:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < DATA_W; i++) f[i % SIG_W] = f[i % SIG_W] ^ y[i];
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  function automatic logic [31:0] model_run(input int n);
    logic [31:0] s;
    s = SEED;
    for (int j = 0; j < n; j++) s = model_step(s, ystream[j]);
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst && sig_valid && sig_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sig: got signature %0h, required no handshake", signature);
      end else begin
        check("scoreboard_sig", signature, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int bound, output int lat);
    lat = 0;
    while (!sig_valid && lat < bound) begin
      tick();
      lat++;
    end
    if (!sig_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: sig_valid=0 after %0d cycles, required 1", bound);
    end
  endtask

  // Start a streamed run; optionally abort or reset at a given sample index.
  task automatic run_stream(input int n, input int abort_at, input int rst_at,
                            input bit push, input bit rdy);
    num_cycles = 16'(n);
    start      = 1'b1;
    sig_ready  = rdy;
    y_in       = '0;
    if (push) exp_q.push_back(model_run(n));
    tick();
    start = 1'b0;
    for (int j = 0; j < n; j++) begin
      y_in = ystream[j];
      if (j == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", sig_valid, 0);
        check("abort_sig_kept", signature, model_run(j));
        return;
      end
      if (j == rst_at) begin
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", sig_valid, 0);
        check("rst_sig", signature, SEED);
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        check("rst_idle_busy", busy, 0);
        return;
      end
      tick();
    end
  endtask

  initial begin
    int lat, l;
    logic [DATA_W-1:0] one;
    logic [255:0]      tmp;
    logic [31:0]       hold_exp;

    for (int i = 0; i < 128; i++) begin
      tmp = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      ystream[i] = tmp[DATA_W-1:0];
    end
    one = 1;
    vt[0] = '{16'd1, '0,          32'hFB3EE249};
    vt[1] = '{16'd1, one,         32'hFB3EE248};
    vt[2] = '{16'd1, one << 32,   32'hFB3EE248};
    vt[3] = '{16'd1, one << 240,  32'hFB3FE249};
    vt[4] = '{16'd0, '0,          32'hFFFFFFFF};
    vt[5] = '{16'd2, '0,          32'hF2BCD925};

    rst = 1'b0; start = 1'b0; abort = 1'b0; sig_ready = 1'b0;
    num_cycles = '0; y_in = '0;
    #1 rst = 1'b1;
    #3;
    check("reset_busy", busy, 0);
    check("reset_valid", sig_valid, 0);
    check("reset_sig", signature, SEED);
    #8 rst = 1'b0;
    tick();

    // Constant-input vectors, ready held high.
    for (int v = 0; v < 6; v++) begin
      num_cycles = vt[v].n;
      y_in       = vt[v].y;
      sig_ready  = 1'b1;
      start      = 1'b1;
      exp_q.push_back(vt[v].exp);
      tick();
      start = 1'b0;
      check("vec_busy", busy, 1);
      wait_valid(20, l);
      lat = l + 1;
      check("vec_latency", lat, vt[v].n + 1);
      tick();
      check("vec_valid_drop", sig_valid, 0);
      check("vec_busy_drop", busy, 0);
    end

    // HOLD back-pressure, ignored start, then start coinciding with the handshake.
    run_stream(3, -1, -1, 1'b1, 1'b0);
    wait_valid(10, l);
    check("hold_latency", l, 0);
    hold_exp = model_run(3);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", sig_valid, 1);
      check("hold_sig", signature, hold_exp);
      if (k == 2) begin
        start = 1'b1;
        num_cycles = 16'd7;
      end
      tick();
      start = 1'b0;
    end
    start = 1'b1;
    num_cycles = 16'd0;
    sig_ready = 1'b1;
    exp_q.push_back(SEED);
    tick();
    check("hs_start_valid", sig_valid, 0);
    check("hs_start_busy", busy, 0);
    tick();
    start = 1'b0;
    check("later_start_valid", sig_valid, 1);
    check("later_start_sig", signature, SEED);
    tick();
    check("later_start_drop", sig_valid, 0);

    // Abort at sample 40 of 100, then a normal run.
    run_stream(100, 40, -1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_abort_valid", sig_valid, 0);
    end
    run_stream(20, -1, -1, 1'b1, 1'b1);
    wait_valid(10, l);
    check("after_abort_latency", l, 0);
    tick();
    check("after_abort_drop", sig_valid, 0);

    // Reset mid-capture, then an identical rerun.
    run_stream(50, -1, 25, 1'b0, 1'b1);
    run_stream(50, -1, -1, 1'b1, 1'b1);
    wait_valid(10, l);
    check("rerun_latency", l, 0);
    tick();
    check("rerun_drop", sig_valid, 0);

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
